odo_job_ctrl: RTL and testbench

Job sequencer that sits between the host job interface and the `miner` Odocrypt/Keccak datapath. It latches a job (header, target, id), drives `start_hash` with a guaranteed restart gap, and tracks how many nonces have been fed. It masks stale pipeline results, captures winning nonces into a tagged result FIFO, and reports job completion.

---
 rtl/odo_job_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_odo_job_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/odo_job_ctrl.sv
// odo_job_ctrl: job sequencer in front of the Odocrypt/Keccak miner datapath.
// Latches a host job, restarts the miner with a guaranteed low gap on
// start_hash, counts fed nonces, drains the pipeline and collects winning
// nonces, tagged with their job id, into a small show-ahead FIFO.
// Optional build macro: ODO_JOB_PREEMPT_EN -- a new job may be accepted in any
// state and restarts the miner at once; by default jobs wait for IDLE.
module odo_job_ctrl #(
  parameter int THROUGHPUT  = 4,
  parameter int PIPE_LAT    = 208,
  parameter int RESTART_GAP = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ID_W        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic [607:0]    job_header,
  input  logic [255:0]    job_target,
  input  logic [ID_W-1:0] job_id,
  input  logic [31:0]     nonce_limit,
  input  logic            abort,
  output logic [607:0]    header,
  output logic [255:0]    target,
  output logic            start_hash,
  input  logic            miner_res,
  input  logic [31:0]     miner_nonce,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_nonce,
  output logic [ID_W-1:0] res_id,
  output logic            job_done,
  output logic            overflow,
  output logic            busy
);

  localparam int GAP_W = $clog2(RESTART_GAP + 1);
  localparam int LAT_W = $clog2(PIPE_LAT + 1);
  localparam int DIV_W = (THROUGHPUT > 1) ? $clog2(THROUGHPUT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ID_W + 32;

  typedef enum logic [1:0] {IDLE, GAP, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [LAT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [LAT_W-1:0]  settle_q, settle_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [31:0]       fed_q, fed_d;
  logic [31:0]       limit_q, limit_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [607:0]      header_q, header_d;
  logic [255:0]      target_q, target_d;
  logic              start_hash_q, start_hash_d;
  logic              job_done_q, job_done_d;
  logic              overflow_q, overflow_d;
  logic              res_d_q, res_d_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic              job_accept;
  logic              settled;
  logic              fifo_full;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              push_drop;
  logic [31:0]       fed_inc;
  logic              div_wrap;

`ifdef ODO_JOB_PREEMPT_EN
  assign job_ready = 1'b1;
`else
  assign job_ready = (state_q == IDLE);
`endif

  assign job_accept = job_valid && job_ready;
  assign settled    = (settle_q == LAT_W'(PIPE_LAT));
  assign div_wrap   = (div_q == DIV_W'(THROUGHPUT - 1));
  assign fed_inc    = div_wrap ? fed_q + 32'd1 : fed_q;

  // Results before the settle counter saturates belong to the previous job.
  assign push_req  = res_d_q && ((state_q == RUN) || (state_q == DRAIN)) && settled;
  assign fifo_full = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop       = res_valid && res_ready;
  assign push      = push_req && (!fifo_full || pop);
  assign push_drop = push_req && fifo_full && !pop;

  assign header     = header_q;
  assign target     = target_q;
  assign start_hash = start_hash_q;
  assign job_done   = job_done_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);
  assign res_valid  = (count_q != '0);
  assign res_nonce  = fifo_mem[rd_ptr_q][31:0];
  assign res_id     = fifo_mem[rd_ptr_q][ENT_W-1:32];

  // Sequencer next-state: gap, run/divide, drain, and job latching.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    div_d        = div_q;
    fed_d        = fed_q;
    limit_d      = limit_q;
    id_d         = id_q;
    header_d     = header_q;
    target_d     = target_q;
    start_hash_d = start_hash_q;
    overflow_d   = overflow_q;
    job_done_d   = 1'b0;
    res_d_d      = miner_res;
    settle_d     = settled ? settle_q : settle_q + LAT_W'(1);

    case (state_q)
      IDLE: begin
        start_hash_d = 1'b0;
      end
      GAP: begin
        start_hash_d = 1'b0;
        if (gap_cnt_q == '0) begin
          state_d      = RUN;
          start_hash_d = 1'b1;
          settle_d     = '0;
          div_d        = '0;
          fed_d        = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      RUN: begin
        start_hash_d = 1'b1;
        div_d        = div_wrap ? '0 : div_q + DIV_W'(1);
        fed_d        = fed_inc;
        if (abort || ((limit_q != '0) && (fed_inc == limit_q))) begin
          state_d     = DRAIN;
          // Loaded one short so DRAIN spans exactly PIPE_LAT clocks.
          drain_cnt_d = LAT_W'(PIPE_LAT - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d      = IDLE;
          start_hash_d = 1'b0;
          job_done_d   = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - LAT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push_drop) begin
      overflow_d = 1'b1;
    end

    // Accept overrides everything: with preemption this restarts a live job
    // and suppresses its job_done.
    if (job_accept) begin
      header_d     = job_header;
      target_d     = job_target;
      id_d         = job_id;
      limit_d      = nonce_limit;
      overflow_d   = 1'b0;
      state_d      = GAP;
      gap_cnt_d    = GAP_W'(RESTART_GAP);
      start_hash_d = 1'b0;
      job_done_d   = 1'b0;
    end
  end

  // Result FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Result storage; the slot written on a full push+pop is the one being read out.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {id_q, miner_nonce};
    end
  end

  // State and control registers; reset drops start_hash and empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      settle_q     <= '0;
      div_q        <= '0;
      fed_q        <= '0;
      limit_q      <= '0;
      id_q         <= '0;
      header_q     <= '0;
      target_q     <= '0;
      start_hash_q <= 1'b0;
      job_done_q   <= 1'b0;
      overflow_q   <= 1'b0;
      res_d_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      settle_q     <= settle_d;
      div_q        <= div_d;
      fed_q        <= fed_d;
      limit_q      <= limit_d;
      id_q         <= id_d;
      header_q     <= header_d;
      target_q     <= target_d;
      start_hash_q <= start_hash_d;
      job_done_q   <= job_done_d;
      overflow_q   <= overflow_d;
      res_d_q      <= res_d_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_odo_job_ctrl.sv
// tb_odo_job_ctrl: directed bench for odo_job_ctrl with a result scoreboard.
// Stimulus pushes each expected FIFO entry into exp_q; the monitor pops and
// compares on every res_valid/res_ready handshake.
module tb_odo_job_ctrl;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          job_valid;
  logic          job_ready;
  logic [607:0]  job_header;
  logic [255:0]  job_target;
  logic [7:0]    job_id;
  logic [31:0]   nonce_limit;
  logic          abort;
  logic [607:0]  header;
  logic [255:0]  target;
  logic          start_hash;
  logic          miner_res;
  logic [31:0]   miner_nonce;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_nonce;
  logic [7:0]    res_id;
  logic          job_done;
  logic          overflow;
  logic          busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] nonce;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  odo_job_ctrl #(
    .THROUGHPUT(4), .PIPE_LAT(208), .RESTART_GAP(2), .FIFO_DEPTH(4), .ID_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .job_target(job_target), .job_id(job_id),
    .nonce_limit(nonce_limit), .abort(abort),
    .header(header), .target(target), .start_hash(start_hash),
    .miner_res(miner_res), .miner_nonce(miner_nonce),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_id(res_id),
    .job_done(job_done), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a job for one clock; header/target are filled with the id byte.
  task automatic accept(input logic [7:0] id, input logic [31:0] lim);
    job_id      = id;
    nonce_limit = lim;
    job_header  = {76{id}};
    job_target  = {32{id}};
    job_valid   = 1'b1;
    check("job_ready_at_offer", job_ready, 1'b1);
    tick();
    job_valid = 1'b0;
    $display("[TB] accept id=0x%0h limit=%0d", id, lim);
    check("header_latched", header[63:0], {8{id}});
    check("target_latched", target[255:192], {8{id}});
    check("busy_after_accept", busy, 1'b1);
  endtask

  // Count clocks after accept with start_hash low; leaves us at RUN entry.
  task automatic wait_run(output int gap);
    gap = 0;
    while (start_hash !== 1'b1 && gap < 20) begin
      tick();
      gap++;
    end
  endtask

  // Scoreboard monitor: compare the head entry on each accepted pop.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got nonce 0x%0h id 0x%0h expected none", res_nonce, res_id);
      end else begin
        mon_e = exp_q.pop_front();
        $display("[TB] result nonce=0x%0h id=0x%0h", res_nonce, res_id);
        check("res_nonce", res_nonce, mon_e.nonce);
        check("res_id", res_id, mon_e.id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int done_at;

    rst_n       = 1'b0;
    job_valid   = 1'b0;
    job_header  = '0;
    job_target  = '0;
    job_id      = '0;
    nonce_limit = '0;
    abort       = 1'b0;
    miner_res   = 1'b0;
    miner_nonce = '0;
    res_ready   = 1'b1;
    tick();
    tick();
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_start_hash", start_hash, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_job_done", job_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_header", header[63:0], 64'h0);
    rst_n = 1'b1;
    tick();

    // Job A: limit 8 -> RUN 32 clocks, DRAIN 208; one stale and one live result.
    accept(8'h11, 32'd8);
    wait_run(gap);
    check("jobA_start_gap", gap, 3);
    done_at = -1;
    for (int n = 0; n < 400; n++) begin
      miner_res = (n == 10 || n == 220);
      if (n == 11)  miner_nonce = 32'hDEAD;
      if (n == 221) miner_nonce = 32'h1234;
      if (n == 220) exp_q.push_back({8'h11, 32'h1234});
      if (n == 12)  check("stale_res_valid", res_valid, 1'b0);
      if (n == 221) check("res_valid_t1", res_valid, 1'b0);
      if (n == 222) begin
        check("res_valid_t2", res_valid, 1'b1);
        check("res_nonce_t2", res_nonce, 32'h1234);
        check("res_id_t2", res_id, 8'h11);
      end
      if (n == 230) check("drain_start_hash", start_hash, 1'b1);
      if (job_done) begin
        done_at = n;
        break;
      end
      tick();
    end
    check("jobA_done_cycle", done_at, 240);
    check("jobA_done_start_hash", start_hash, 1'b0);
    check("jobA_done_job_ready", job_ready, 1'b1);
    check("jobA_done_busy", busy, 1'b0);
    tick();
    check("jobA_done_single", job_done, 1'b0);

    // Job B: unlimited, abort at RUN clock 100; five results into a depth-4 FIFO.
    res_ready = 1'b0;
    accept(8'h22, 32'd0);
    wait_run(gap);
    check("jobB_start_gap", gap, 3);
    done_at = -1;
    for (int n = 0; n < 600; n++) begin
      abort     = (n == 100);
      miner_res = (n >= 220 && n <= 228 && (n % 2) == 0);
      if (n >= 221 && n <= 229 && (n % 2) == 1) miner_nonce = 32'hA0 + 32'((n - 221) / 2);
      if (miner_res && n <= 226) exp_q.push_back({8'h22, 32'hA0 + 32'((n - 220) / 2)});
`ifdef ODO_JOB_PREEMPT_EN
      if (n == 50) check("run_job_ready", job_ready, 1'b1);
`else
      if (n == 50) check("run_job_ready", job_ready, 1'b0);
`endif
      if (n == 229) check("overflow_before_drop", overflow, 1'b0);
      if (n == 231) begin
        check("overflow_after_drop", overflow, 1'b1);
        check("full_res_valid", res_valid, 1'b1);
        check("full_head_nonce", res_nonce, 32'hA0);
      end
      if (job_done) begin
        done_at = n;
        break;
      end
      tick();
    end
    abort = 1'b0;
    check("jobB_abort_done_cycle", done_at, 309);
    check("overflow_sticky_idle", overflow, 1'b1);

    // Job C: limit 1; accept clears overflow but keeps the queued results.
    accept(8'h33, 32'd1);
    check("accept_clears_overflow", overflow, 1'b0);
    check("fifo_kept_on_accept", res_valid, 1'b1);
    check("fifo_head_id_kept", res_id, 8'h22);
    res_ready = 1'b1;
    wait_run(gap);
    check("jobC_start_gap", gap, 3);
    done_at = -1;
    for (int n = 0; n < 400; n++) begin
      if (job_done) begin
        done_at = n;
        break;
      end
      tick();
    end
    check("jobC_done_cycle", done_at, 212);
    check("scoreboard_empty", exp_q.size(), 0);
    check("fifo_drained", res_valid, 1'b0);

`ifdef ODO_JOB_PREEMPT_EN
    // Preemption: a job offered mid-RUN restarts the miner with no job_done.
    accept(8'h66, 32'd0);
    wait_run(gap);
    for (int n = 0; n < 20; n++) tick();
    accept(8'h77, 32'd1);
    check("preempt_start_hash_low", start_hash, 1'b0);
    wait_run(gap);
    check("preempt_start_gap", gap, 3);
    done_at = -1;
    for (int n = 0; n < 400; n++) begin
      if (job_done) begin
        done_at = n;
        break;
      end
      tick();
    end
    check("preempt_done_cycle", done_at, 212);
`endif

    // Job D: leave one result queued, then reset asynchronously mid-job.
    res_ready = 1'b0;
    accept(8'h44, 32'd0);
    wait_run(gap);
    for (int n = 0; n < 212; n++) begin
      miner_res = (n == 210);
      if (n == 211) miner_nonce = 32'h55;
      tick();
    end
    miner_res = 1'b0;
    check("jobD_res_queued", res_valid, 1'b1);
    check("jobD_res_nonce", res_nonce, 32'h55);
    check("jobD_res_id", res_id, 8'h44);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_start_hash", start_hash, 1'b0);
    check("async_rst_res_valid", res_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_job_ready", job_ready, 1'b1);
    check("async_rst_header", header[63:0], 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", busy, 1'b0);
    check("post_rst_job_done", job_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
